div_issue_sched: RTL and testbench
==================================

// Module: div_issue_sched
// PURPOSE
//  Sequences the shared 16/16 divider for the integer-divide issue stage:
//  - Arbitrates round-robin between two reservation-station requesters.
//  - Launches one divide at a time.
//  - Times the divider latency.
//  - Holds the 32-bit result and tag until the CDB grants a broadcast.
//  - Handles divide-by-zero without using the divider.
//  - Discards in-flight work on a pipeline flush.
// PARAMETERS
//  LATENCY  18  cycles from div_ce to a valid div_quot (>=1)
//  DATA_W   16  operand width
//  TAG_W    6   ROB/rename tag width
// PORTS
//  clk           in   1       system clock, all state on posedge
//  reset         in   1       synchronous reset, active-low (0 = reset)
//  reqN_valid    in   1       N=0,1: requester N has a divide ready
//  reqN_rs       in   DATA_W  dividend from requester N
//  reqN_rt       in   DATA_W  divisor from requester N
//  reqN_tag      in   TAG_W   destination tag from requester N
//  reqN_ready    out  1       accept strobe; valid&ready = transfer
//  div_ce        out  1       divider clock-enable, one-cycle launch pulse
//  div_dividend  out  DATA_W  registered dividend to the divider
//  div_divisor   out  DATA_W  registered divisor to the divider
//  div_quot      in   2*DATA_W  divider result
//  cdb_req       out  1       result broadcast request
//  cdb_grant     in   1       CDB grant, sampled while cdb_req=1
//  cdb_data      out  2*DATA_W  result
//  cdb_tag       out  TAG_W   result tag
//  cdb_divzero   out  1       result came from a divide by zero
//  flush         in   1       kill any in-flight op
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset (reset=0 at posedge): all outputs and registers go to 0.
//   - state=IDLE, rr_ptr=0.
//   - This applies in any state; the in-flight op is lost.
//  FSM states: IDLE, LAUNCH, WAIT, CDB.
//  IDLE
//   - reqN_ready is combinational, high only in IDLE with flush=0.
//   - Only the selected requester sees ready; at most one ready per cycle.
//   - Both valid: select rr_ptr.
//   - One valid: select that one.
//   - On accept:
//     - Latch rs, rt and tag.
//     - Set rr_ptr to the non-selected requester.
//     - If rt==0, go to CDB with data=0 and divzero=1.
//     - Otherwise go to LAUNCH.
//  LAUNCH
//   - div_ce=1 for exactly this cycle; operands stable.
//   - cnt <= LATENCY-1; go to WAIT.
//  WAIT
//   - If cnt==0: capture div_quot into the result register, go to CDB.
//   - Otherwise cnt--.
//  CDB
//   - cdb_req=1 with data, tag and divzero held stable.
//   - On cdb_grant=1, go to IDLE.
//   - No new accept in the grant cycle.
//  Latency for accept in cycle N:
//   - div_ce in cycle N+1.
//   - First cdb_req in cycle N+LATENCY+2.
//   - Divide-by-zero: cdb_req in cycle N+1.
//  Throughput: one op per LATENCY+3 cycles at best (immediate grant).
//  div_ce=0 and cdb_req=0 in every state other than those above.
//  flush=1
//   - Any state: next state IDLE; result dropped, cdb_req low next cycle.
//   - Takes priority over cdb_grant in the same cycle.
//   - Blocks accept in IDLE.
//   - Divider output from a killed op is ignored (cnt is not carried over).
//  cdb_grant while cdb_req=0: ignored.
//  reqN_* changes while ready=0: ignored.
//  Outputs cdb_data, cdb_tag and cdb_divzero are registered.
//   - They hold their last value outside CDB.
//   - The bench checks them only while cdb_req=1.
// TESTING
//  1. Single divide, LATENCY=18, div model returns rs/rt:
//     req0 rs=100, rt=7, tag=5, accepted cycle N.
//     -> div_ce at N+1; cdb_req at N+20 with data=14, tag=5, divzero=0.
//  2. Both requesters valid, rr_ptr=0, immediate grants:
//     -> req0 accepted first, then req1 on the next IDLE.
//     -> Both valid again: req0 wins (fairness alternates).
//  3. Divide by zero: req1 rs=9, rt=0, tag=12, accepted cycle N.
//     -> No div_ce; cdb_req at N+1 with data=0, tag=12, divzero=1.
//  4. CDB backpressure: cdb_grant low 5 cycles after cdb_req rises.
//     -> cdb_req, data and tag stable all 5 cycles.
//     -> Both reqN_ready stay 0; IDLE the cycle after grant.
//  5. Flush in WAIT with cnt=3:
//     -> IDLE next cycle; no cdb_req for that tag.
//     -> A new op accepted next gets a full LATENCY wait and the correct result.
//  6. reset=0 asserted mid-CDB with cdb_grant=1 in the same cycle:
//     -> All outputs 0, busy=0, rr_ptr=0 next cycle; no broadcast completes.

Source files
------------

// File: rtl/div_issue_sched.sv
// Round-robin issue of 16/16 divides to a shared fixed-latency divider; accept->div_ce is 1 cycle, accept->cdb_req is LATENCY+2 (1 for divide-by-zero).
// Holds one result until cdb_grant; requesters see ready only while idle, so backpressure is a single-op window.
module div_issue_sched #(
  parameter int LATENCY = 18,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0_valid,
  input  logic [DATA_W-1:0]     i_req0_rs,
  input  logic [DATA_W-1:0]     i_req0_rt,
  input  logic [TAG_W-1:0]      i_req0_tag,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [DATA_W-1:0]     i_req1_rs,
  input  logic [DATA_W-1:0]     i_req1_rt,
  input  logic [TAG_W-1:0]      i_req1_tag,
  output logic                  o_req1_ready,
  output logic                  o_div_ce,
  output logic [DATA_W-1:0]     o_div_dividend,
  output logic [DATA_W-1:0]     o_div_divisor,
  input  logic [2*DATA_W-1:0]   i_div_quot,
  output logic                  o_cdb_req,
  input  logic                  i_cdb_grant,
  output logic [2*DATA_W-1:0]   o_cdb_data,
  output logic [TAG_W-1:0]      o_cdb_tag,
  output logic                  o_cdb_divzero,
  input  logic                  i_flush,
  output logic                  o_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_CDB    = 2'd3;

  localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  logic [1:0]          r_state;
  logic                r_rr_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_dividend;
  logic [DATA_W-1:0]   r_divisor;
  logic [TAG_W-1:0]    r_tag;
  logic [2*DATA_W-1:0] r_data;
  logic                r_divzero;

  logic                w_idle;
  logic                w_sel;
  logic                w_ready0;
  logic                w_ready1;
  logic                w_accept;
  logic [DATA_W-1:0]   w_rs;
  logic [DATA_W-1:0]   w_rt;
  logic [TAG_W-1:0]    w_tag;

  // With both requesters pending the pointer decides; otherwise the lone valid one wins.
  assign w_idle   = (r_state == S_IDLE);
  assign w_sel    = (i_req0_valid && i_req1_valid) ? r_rr_ptr : ~i_req0_valid;
  assign w_ready0 = w_idle && !i_flush && i_req0_valid && !w_sel;
  assign w_ready1 = w_idle && !i_flush && i_req1_valid && w_sel;
  assign w_accept = w_ready0 || w_ready1;
  assign w_rs     = w_sel ? i_req1_rs  : i_req0_rs;
  assign w_rt     = w_sel ? i_req1_rt  : i_req0_rt;
  assign w_tag    = w_sel ? i_req1_tag : i_req0_tag;

  assign o_req0_ready   = w_ready0;
  assign o_req1_ready   = w_ready1;
  assign o_div_ce       = (r_state == S_LAUNCH);
  assign o_div_dividend = r_dividend;
  assign o_div_divisor  = r_divisor;
  assign o_cdb_req      = (r_state == S_CDB);
  assign o_cdb_data     = r_data;
  assign o_cdb_tag      = r_tag;
  assign o_cdb_divzero  = r_divzero;
  assign o_busy         = !w_idle;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 1'b0;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_tag      <= '0;
      r_data     <= '0;
      r_divzero  <= 1'b0;
    end else if (i_flush) begin
      // Killed work is simply abandoned; the counter is reloaded on the next launch.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dividend <= w_rs;
            r_divisor  <= w_rt;
            r_tag      <= w_tag;
            r_rr_ptr   <= ~w_sel;
            if (w_rt == '0) begin
              r_data    <= '0;
              r_divzero <= 1'b1;
              r_state   <= S_CDB;
            end else begin
              r_divzero <= 1'b0;
              r_state   <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_cnt   <= CNT_INIT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_data  <= i_div_quot;
            r_state <= S_CDB;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_CDB: begin
          if (i_cdb_grant) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_sched.sv
// Bench for div_issue_sched: hand table, flush/reset corner sequences, then random ops against a reference model.
module tb_div_issue_sched;

  localparam int LATENCY = 18;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_rs, req0_rt, req1_rs, req1_rt;
  logic [5:0]  req0_tag, req1_tag;
  logic        req0_ready, req1_ready;
  logic        div_ce;
  logic [15:0] div_dividend, div_divisor;
  logic [31:0] div_quot;
  logic        cdb_req, cdb_grant;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_tag;
  logic        cdb_divzero;
  logic        flush;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  logic m_rr;

  div_issue_sched #(.LATENCY(LATENCY), .DATA_W(16), .TAG_W(6)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req0_valid(req0_valid), .i_req0_rs(req0_rs), .i_req0_rt(req0_rt),
    .i_req0_tag(req0_tag), .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_rs(req1_rs), .i_req1_rt(req1_rt),
    .i_req1_tag(req1_tag), .o_req1_ready(req1_ready),
    .o_div_ce(div_ce), .o_div_dividend(div_dividend), .o_div_divisor(div_divisor),
    .i_div_quot(div_quot),
    .o_cdb_req(cdb_req), .i_cdb_grant(cdb_grant), .o_cdb_data(cdb_data),
    .o_cdb_tag(cdb_tag), .o_cdb_divzero(cdb_divzero),
    .i_flush(flush), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: the quotient is only presented in the single cycle LATENCY after the launch.
  logic [31:0] dm_res = 32'h0;
  int          dm_age = 1000;
  always @(posedge clk) begin
    if (div_ce) begin
      dm_res <= (div_divisor == 16'd0) ? 32'hFFFF_FFFF : {16'd0, div_dividend / div_divisor};
      dm_age <= 1;
    end else if (dm_age < 1000) begin
      dm_age <= dm_age + 1;
    end
  end
  assign div_quot = (dm_age == LATENCY) ? dm_res : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_rs = 16'd0; req0_rt = 16'd0; req0_tag = 6'd0;
    req1_rs = 16'd0; req1_rt = 16'd0; req1_tag = 6'd0;
    cdb_grant = 1'b0; flush = 1'b0;
  endtask

  // One complete op: accept, latency, result, gd cycles of CDB backpressure, grant.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [15:0] rs0, input logic [15:0] rt0, input logic [5:0] tag0,
                        input logic [15:0] rs1, input logic [15:0] rt1, input logic [5:0] tag1,
                        input int gd, input logic exp_sel, input logic [31:0] exp_data,
                        input logic exp_dz);
    int k;
    int ce_cnt;
    int ce_at;
    logic [15:0] e_rs, e_rt;
    logic [5:0]  e_tag;
    e_rs  = exp_sel ? rs1 : rs0;
    e_rt  = exp_sel ? rt1 : rt0;
    e_tag = exp_sel ? tag1 : tag0;
    @(negedge clk);
    req0_valid = v0; req0_rs = rs0; req0_rt = rt0; req0_tag = tag0;
    req1_valid = v1; req1_rs = rs1; req1_rt = rt1; req1_tag = tag1;
    #1;
    chk("ready0_accept", 32'(req0_ready), 32'(v0 && !exp_sel));
    chk("ready1_accept", 32'(req1_ready), 32'(v1 && exp_sel));
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    ce_cnt = 0; ce_at = -1; k = 1;
    while (!cdb_req && k < 60) begin
      if (div_ce) begin
        ce_cnt++;
        if (ce_at < 0) ce_at = k;
        chk("div_dividend", 32'(div_dividend), 32'(e_rs));
        chk("div_divisor", 32'(div_divisor), 32'(e_rt));
      end
      @(negedge clk);
      k++;
    end
    m_rr = !exp_sel;
    chk("cdb_latency", k, exp_dz ? 32'd1 : 32'(LATENCY + 2));
    chk("div_ce_count", ce_cnt, exp_dz ? 32'd0 : 32'd1);
    chk("div_ce_cycle", ce_at, exp_dz ? 32'hFFFF_FFFF : 32'd1);
    chk("cdb_data", cdb_data, exp_data);
    chk("cdb_tag", 32'(cdb_tag), 32'(e_tag));
    chk("cdb_divzero", 32'(cdb_divzero), 32'(exp_dz));
    for (int i = 0; i < gd; i++) begin
      req0_valid = 1'b1; req0_rs = 16'd3; req0_rt = 16'd1;
      req1_valid = 1'b1; req1_rs = 16'd4; req1_rt = 16'd1;
      #1;
      chk("hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("hold_cdb_req", 32'(cdb_req), 32'd1);
      chk("hold_data", cdb_data, exp_data);
      chk("hold_tag", 32'(cdb_tag), 32'(e_tag));
      @(negedge clk);
    end
    cdb_grant = 1'b1;
    req0_valid = 1'b1; req0_rs = 16'd3; req0_rt = 16'd1;
    req1_valid = 1'b1; req1_rs = 16'd4; req1_rt = 16'd1;
    #1;
    chk("grant_cycle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    cdb_grant = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("idle_after_grant", 32'(busy), 32'd0);
    chk("req_low_after_grant", 32'(cdb_req), 32'd0);
  endtask

  // Accept a requester-0 op and stop at the first cycle of cdb_req.
  task automatic start_to_cdb(input logic [15:0] rs, input logic [15:0] rt, input logic [5:0] tag);
    int k;
    @(negedge clk);
    req0_valid = 1'b1; req0_rs = rs; req0_rt = rt; req0_tag = tag;
    @(negedge clk);
    req0_valid = 1'b0;
    m_rr = 1'b1;
    k = 1;
    while (!cdb_req && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("reach_cdb", 32'(cdb_req), 32'd1);
  endtask

  typedef struct {
    logic        v0, v1;
    logic [15:0] rs0, rt0;
    logic [5:0]  tag0;
    logic [15:0] rs1, rt1;
    logic [5:0]  tag1;
    int          gd;
    logic        sel;
    logic [31:0] data;
    logic        dz;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int cnt;
    logic        v0, v1, sel;
    logic [15:0] rs0, rt0, rs1, rt1, ers, ert;
    logic [5:0]  tg0, tg1;

    tbl[0] = '{1'b1, 1'b1, 16'd50,   16'd5, 6'd1,  16'd81,     16'd9, 6'd2,  0, 1'b0, 32'd10,    1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'd50,   16'd5, 6'd1,  16'd81,     16'd9, 6'd2,  0, 1'b1, 32'd9,     1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'd1000, 16'd3, 6'd3,  16'd7,      16'd7, 6'd4,  0, 1'b0, 32'd333,   1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'd100,  16'd7, 6'd5,  16'd0,      16'd0, 6'd0,  0, 1'b0, 32'd14,    1'b0};
    tbl[4] = '{1'b0, 1'b1, 16'd0,    16'd0, 6'd0,  16'd9,      16'd0, 6'd12, 0, 1'b1, 32'd0,     1'b1};
    tbl[5] = '{1'b1, 1'b0, 16'd60000, 16'd3, 6'd7, 16'd0,      16'd0, 6'd0,  5, 1'b0, 32'd20000, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'd0,    16'd0, 6'd0,  16'hFFFF,   16'd1, 6'd63, 2, 1'b1, 32'd65535, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 16'd5,    16'd9, 6'd8,  16'd0,      16'd0, 6'd9,  1, 1'b0, 32'd0,     1'b0};
    tbl[8] = '{1'b1, 1'b1, 16'd1,    16'd1, 6'd10, 16'd0,      16'd0, 6'd11, 0, 1'b1, 32'd0,     1'b1};

    idle_inputs();
    reset = 1'b0;
    m_rr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cdb_req", 32'(cdb_req), 32'd0);
    chk("rst_div_ce", 32'(div_ce), 32'd0);
    chk("rst_cdb_data", cdb_data, 32'd0);
    chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].v0, tbl[i].v1, tbl[i].rs0, tbl[i].rt0, tbl[i].tag0,
             tbl[i].rs1, tbl[i].rt1, tbl[i].tag1, tbl[i].gd, tbl[i].sel, tbl[i].data, tbl[i].dz);

    // Flush while the divider has 3 cycles to go.
    @(negedge clk);
    req0_valid = 1'b1; req0_rs = 16'd500; req0_rt = 16'd4; req0_tag = 6'd20;
    @(negedge clk);
    req0_valid = 1'b0;
    m_rr = 1'b1;
    for (int i = 1; i < 16; i++) @(negedge clk);
    chk("pre_flush_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_wait_busy", 32'(busy), 32'd0);
    chk("flush_wait_req", 32'(cdb_req), 32'd0);
    flush = 1'b1; req1_valid = 1'b1; req1_rs = 16'd8; req1_rt = 16'd2; req1_tag = 6'd22;
    #1;
    chk("flush_blocks_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; req1_valid = 1'b0;
    chk("flush_idle_no_accept", 32'(busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (cdb_req) cnt++;
    end
    chk("killed_no_broadcast", cnt, 32'd0);
    run_op(1'b1, 1'b0, 16'd12345, 16'd5, 6'd21, 16'd0, 16'd0, 6'd0, 0, 1'b0, 32'd2469, 1'b0);

    // Flush in CDB beats a simultaneous grant and drops the result.
    start_to_cdb(16'd200, 16'd10, 6'd30);
    flush = 1'b1; cdb_grant = 1'b1;
    @(negedge clk);
    flush = 1'b0; cdb_grant = 1'b0;
    chk("flush_cdb_req", 32'(cdb_req), 32'd0);
    chk("flush_cdb_busy", 32'(busy), 32'd0);

    // Reset mid-CDB with a grant in the same cycle.
    start_to_cdb(16'd77, 16'd7, 6'd33);
    reset = 1'b0; cdb_grant = 1'b1;
    @(negedge clk);
    reset = 1'b1; cdb_grant = 1'b0;
    m_rr = 1'b0;
    chk("mid_rst_cdb_req", 32'(cdb_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_div_ce", 32'(div_ce), 32'd0);
    chk("mid_rst_dividend", 32'(div_dividend), 32'd0);
    chk("mid_rst_divisor", 32'(div_divisor), 32'd0);
    chk("mid_rst_data", cdb_data, 32'd0);
    chk("mid_rst_tag", 32'(cdb_tag), 32'd0);
    chk("mid_rst_divzero", 32'(cdb_divzero), 32'd0);
    run_op(1'b1, 1'b1, 16'd90, 16'd9, 6'd40, 16'd8, 16'd2, 6'd41, 0, 1'b0, 32'd10, 1'b0);

    // Random ops against the reference: rr alternates on ties, result is rs/rt or a zero divide.
    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      rs0 = 16'($urandom); rs1 = 16'($urandom);
      rt0 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      rt1 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      tg0 = 6'($urandom); tg1 = 6'($urandom);
      sel = (v0 && v1) ? m_rr : !v0;
      ers = sel ? rs1 : rs0;
      ert = sel ? rt1 : rt0;
      run_op(v0, v1, rs0, rt0, tg0, rs1, rt1, tg1, $urandom_range(0, 3), sel,
             (ert == 16'd0) ? 32'd0 : {16'd0, ers / ert}, (ert == 16'd0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "timeout");
  end

endmodule
